ex_seq_ctrl: RTL and testbench

EX_SEQ_CTRL -- requirements
Module: ex_seq_ctrl

---
 rtl/ex_seq_ctrl_pkg.sv | 24 ++
 rtl/ex_elem_buf.sv | 39 +++
 rtl/ex_seq_ctrl.sv | 153 +++++++++++++++
 tb/tb_ex_seq_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_seq_ctrl_pkg.sv
//------------------------------------------------------------------------------
// ex_seq_ctrl_pkg : shared state encoding and widths for the Ex sequencer
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package ex_seq_ctrl_pkg;

  localparam int N_ELEM = 8;
  localparam int X_W    = 9;
  localparam int MEAN_W = 22;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_FEED  = 3'd3,
    ST_WAIT  = 3'd4,
    ST_OUT   = 3'd5
  } state_t;

endpackage

`default_nettype wire

// File: rtl/ex_elem_buf.sv
//------------------------------------------------------------------------------
// ex_elem_buf : small element store, one write port, async read by pointer
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ex_elem_buf
  import ex_seq_ctrl_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = 9
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_ptr,
  input  logic [W-1:0]             wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_ptr,
  output logic [W-1:0]             rd_data
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

`default_nettype wire

// File: rtl/ex_seq_ctrl.sv
//------------------------------------------------------------------------------
// ex_seq_ctrl : collects an 8-element token and sequences it into the Ex unit
// Optional done-wait watchdog: define EX_SEQ_TIMEOUT_EN.  Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ex_seq_ctrl #(
  parameter int N_ELEM      = ex_seq_ctrl_pkg::N_ELEM,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                               i_clk,
  input  logic                               i_rstn,
  input  logic                               s_valid,
  output logic                               s_ready,
  input  logic [ex_seq_ctrl_pkg::X_W-1:0]    s_x,
  input  logic                               s_last,
  input  logic [1:0]                         i_alpha,
  input  logic [7:0]                         i_inv_n,
  output logic                               o_ex_valid,
  output logic [ex_seq_ctrl_pkg::X_W-1:0]    o_ex_x,
  output logic [1:0]                         o_ex_alpha,
  output logic [7:0]                         o_ex_inv_n,
  input  logic                               i_ex_done,
  input  logic [ex_seq_ctrl_pkg::MEAN_W-1:0] i_ex_mean,
  output logic                               m_valid,
  input  logic                               m_ready,
  output logic [ex_seq_ctrl_pkg::MEAN_W-1:0] m_mean,
  output logic                               o_err
);

  import ex_seq_ctrl_pkg::*;

  localparam int                CNT_W    = $clog2(N_ELEM);
  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(N_ELEM - 1);

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [1:0]          alpha_q;
  logic [7:0]          inv_n_q;
  logic [MEAN_W-1:0]   mean_q;
  logic                err_q;
  logic [X_W-1:0]      rd_data;
  logic                accept;
  logic                wd_expire;

  assign accept = (state == ST_LOAD) && s_valid;

  ex_elem_buf #(
    .DEPTH (N_ELEM),
    .W     (X_W)
  ) u_buf (
    .clk     (i_clk),
    .rst_n   (i_rstn),
    .clr     (state == ST_IDLE),
    .wr_en   (accept),
    .wr_ptr  (cnt),
    .wr_data (s_x),
    .rd_ptr  (cnt),
    .rd_data (rd_data)
  );

`ifdef EX_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_cnt;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)                wd_cnt <= '0;
    else if (state == ST_WAIT)  wd_cnt <= wd_cnt + 1'b1;
    else                        wd_cnt <= '0;
  end

  assign wd_expire = (state == ST_WAIT) && !i_ex_done &&
                     (wd_cnt == WD_W'(TIMEOUT_CYC - 1));
`else
  assign wd_expire = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // One counter serves as write pointer in LOAD and read pointer in FEED.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      cnt <= '0;
    end else if (state == ST_IDLE || state == ST_START) begin
      cnt <= '0;
    end else if (accept || state == ST_FEED) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      alpha_q <= '0;
      inv_n_q <= '0;
      mean_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept && cnt == '0) begin
        alpha_q <= i_alpha;
        inv_n_q <= i_inv_n;
      end
      if (state == ST_WAIT && i_ex_done) mean_q <= i_ex_mean;
      else if (wd_expire)                mean_q <= '0;
      if ((accept && (s_last != (cnt == LAST_IDX))) ||
          (i_ex_done && state != ST_WAIT) || wd_expire)
        err_q <= 1'b1;
    end
  end

  always_comb begin
    state_nxt  = state;
    s_ready    = 1'b0;
    o_ex_valid = 1'b0;
    o_ex_x     = '0;
    m_valid    = 1'b0;
    case (state)
      ST_IDLE:  state_nxt = ST_LOAD;
      ST_LOAD: begin
        s_ready = 1'b1;
        if (accept && cnt == LAST_IDX) state_nxt = ST_START;
      end
      // Lead-in beat with x=0: the Ex unit spends it entering accumulation.
      ST_START: begin
        o_ex_valid = 1'b1;
        state_nxt  = ST_FEED;
      end
      ST_FEED: begin
        o_ex_valid = 1'b1;
        o_ex_x     = rd_data;
        if (cnt == LAST_IDX) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_ex_done || wd_expire) state_nxt = ST_OUT;
      end
      ST_OUT: begin
        m_valid = 1'b1;
        if (m_ready) state_nxt = ST_IDLE;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign o_ex_alpha = alpha_q;
  assign o_ex_inv_n = inv_n_q;
  assign m_mean     = mean_q;
  assign o_err      = err_q;

endmodule

`default_nettype wire

// File: tb/tb_ex_seq_ctrl.sv
//------------------------------------------------------------------------------
// tb_ex_seq_ctrl : directed bench for ex_seq_ctrl with a behavioural Ex unit
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_ex_seq_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        s_valid, s_ready, s_last;
  logic [8:0]  s_x;
  logic [1:0]  i_alpha;
  logic [7:0]  i_inv_n;
  logic        ex_valid;
  logic [8:0]  ex_x;
  logic [1:0]  ex_alpha;
  logic [7:0]  ex_inv_n;
  logic        ex_done;
  logic [21:0] ex_mean;
  logic        m_valid, m_ready;
  logic [21:0] m_mean;
  logic        err;

  logic        mdl_en;
  logic        mdl_acc;
  int          mdl_cnt;
  int          mdl_sum;
  logic        mdl_done;
  logic [21:0] mdl_mean;
  logic        spur_done;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  assign ex_done = mdl_done | spur_done;
  assign ex_mean = mdl_mean;

  ex_seq_ctrl #(.N_ELEM(8), .TIMEOUT_CYC(16)) dut (
    .i_clk      (clk),
    .i_rstn     (rstn),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_x        (s_x),
    .s_last     (s_last),
    .i_alpha    (i_alpha),
    .i_inv_n    (i_inv_n),
    .o_ex_valid (ex_valid),
    .o_ex_x     (ex_x),
    .o_ex_alpha (ex_alpha),
    .o_ex_inv_n (ex_inv_n),
    .i_ex_done  (ex_done),
    .i_ex_mean  (ex_mean),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_mean     (m_mean),
    .o_err      (err)
  );

  // Ex unit: first valid beat enters accumulation, next 8 beats accumulate
  // (x << alpha), then mean = (sum * inv_n) >>> 8 with done one cycle later.
  always @(posedge clk or negedge rstn) begin
    int xv;
    int tot;
    if (!rstn) begin
      mdl_acc  <= 1'b0;
      mdl_cnt  <= 0;
      mdl_sum  <= 0;
      mdl_done <= 1'b0;
      mdl_mean <= '0;
    end else begin
      mdl_done <= 1'b0;
      if (ex_valid) begin
        if (!mdl_acc) begin
          mdl_acc <= 1'b1;
          mdl_cnt <= 0;
          mdl_sum <= 0;
        end else begin
          xv      = int'($signed(ex_x)) <<< ex_alpha;
          tot     = mdl_sum + xv;
          mdl_sum <= tot;
          mdl_cnt <= mdl_cnt + 1;
          if (mdl_cnt == 7) begin
            mdl_acc  <= 1'b0;
            mdl_done <= mdl_en;
            mdl_mean <= 22'((tot * int'(ex_inv_n)) >>> 8);
          end
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_token(input logic [8:0] x, input logic [1:0] a, input logic [7:0] inv,
                            input int last_beat, input int nbeats, input bit gap);
    int   n;
    int   guard;
    bit   ph;
    logic rdy;
    n = 0; guard = 0; ph = 1'b0;
    while (n < nbeats && guard < 100) begin
      @(negedge clk);
      s_valid = !(gap && ph);
      s_x     = x;
      s_last  = (n == last_beat);
      i_alpha = a;
      i_inv_n = inv;
      rdy     = s_ready;
      @(posedge clk);
      if (s_valid && rdy) n++;
      ph = !ph;
      guard++;
    end
    check("beats_accepted", n, nbeats);
  endtask

  task automatic collect(input logic [21:0] exp_mean, input int exp_lat, input logic [1:0] exp_a,
                         input logic [7:0] exp_inv, input int stall);
    int         lat;
    int         vcnt;
    logic [8:0] first_x;
    logic [1:0] a_seen;
    logic [7:0] inv_seen;
    bit         rdy_seen;
    lat = 0; vcnt = 0; first_x = '1; a_seen = '0; inv_seen = '0; rdy_seen = 1'b0;
    do begin
      @(negedge clk);
      s_valid = 1'b0;
      s_last  = 1'b0;
      lat++;
      if (ex_valid) begin
        if (vcnt == 0) begin
          first_x  = ex_x;
          a_seen   = ex_alpha;
          inv_seen = ex_inv_n;
        end
        vcnt++;
      end
      if (s_ready) rdy_seen = 1'b1;
    end while (!m_valid && lat < 100);
    check("latency", lat, exp_lat);
    check("ex_valid_cycles", vcnt, 9);
    check("start_x", first_x, 9'd0);
    check("ex_alpha", a_seen, exp_a);
    check("ex_inv_n", inv_seen, exp_inv);
    check("s_ready_busy", rdy_seen, 1'b0);
    check("mean", m_mean, exp_mean);
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      check("stall_mean", m_mean, exp_mean);
      check("stall_valid", m_valid, 1'b1);
      check("stall_ready", s_ready, 1'b0);
    end
    @(negedge clk);
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    check("idle_mvalid", m_valid, 1'b0);
    check("idle_sready", s_ready, 1'b0);
    @(negedge clk);
    check("load_sready", s_ready, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_ready"}, s_ready, 1'b0);
    check({tag, "_ex_valid"}, ex_valid, 1'b0);
    check({tag, "_ex_x"}, ex_x, 9'd0);
    check({tag, "_ex_alpha"}, ex_alpha, 2'd0);
    check({tag, "_ex_inv_n"}, ex_inv_n, 8'd0);
    check({tag, "_m_valid"}, m_valid, 1'b0);
    check({tag, "_m_mean"}, m_mean, 22'd0);
    check({tag, "_err"}, err, 1'b0);
  endtask

  initial begin
    bit seen;
    rstn = 1'b0; s_valid = 1'b0; s_x = '0; s_last = 1'b0; i_alpha = '0; i_inv_n = '0;
    m_ready = 1'b0; mdl_en = 1'b1; spur_done = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rstn = 1'b1;

    // x=1, alpha=0, inv_n=32 -> mean 1
    send_token(9'd1, 2'd0, 8'd32, 7, 8, 1'b0);
    collect(22'd1, 11, 2'd0, 8'd32, 0);
    check("err_t1", err, 1'b0);

    // x=-4, alpha=2 -> mean -16
    send_token(9'h1FC, 2'd2, 8'd32, 7, 8, 1'b0);
    collect(22'h3FFFF0, 11, 2'd2, 8'd32, 0);

    // gapped input, 5-cycle output stall: x=3, alpha=1 -> mean 6
    send_token(9'd3, 2'd1, 8'd32, 7, 8, 1'b1);
    collect(22'd6, 11, 2'd1, 8'd32, 5);
    check("err_t3", err, 1'b0);

    // early s_last on beat 3: x=2 -> mean 2, error flagged
    send_token(9'd2, 2'd0, 8'd32, 3, 8, 1'b0);
    collect(22'd2, 11, 2'd0, 8'd32, 0);
    check("err_early_last", err, 1'b1);
    repeat (3) @(negedge clk);
    check("err_sticky", err, 1'b1);

    // reset after 5 beats
    send_token(9'd7, 2'd3, 8'd99, 7, 5, 1'b0);
    @(negedge clk);
    s_valid = 1'b0;
    rstn = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rstn = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (m_valid) seen = 1'b1;
    end
    check("no_stale_mvalid", seen, 1'b0);
    send_token(9'd5, 2'd1, 8'd64, 7, 8, 1'b0);
    collect(22'd20, 11, 2'd1, 8'd64, 0);
    check("err_after_rst", err, 1'b0);

    // done pulse outside WAIT
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    check("err_spurious_done", err, 1'b1);
    check("spurious_no_mvalid", m_valid, 1'b0);

`ifdef EX_SEQ_TIMEOUT_EN
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    mdl_en = 1'b0;
    send_token(9'd9, 2'd0, 8'd32, 7, 8, 1'b0);
    collect(22'd0, 26, 2'd0, 8'd32, 0);
    check("err_timeout", err, 1'b1);
    mdl_en = 1'b1;
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
